// File: rtl/mem_dbg_pkg.sv
// Shared constants and FSM encoding for the UART debug memory loader.
package mem_dbg_pkg;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, CNT, WD_H, WD_L, WSTORE, RREQ, RWAIT, TX_H, TX_L, RESP
  } state_t;
endpackage

// File: rtl/mem_dbg_loader.sv
// UART debug loader: parses word-write/read frames, drives the CPU's SW/LW
// memory port while holding the CPU off the bus, and returns data/status bytes.
module mem_dbg_loader
  import mem_dbg_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_cpu_hold,
  output logic [15:0] o_mem_ad,
  output logic [15:0] o_mem_do,
  output logic        o_mem_sw,
  output logic        o_mem_lw,
  input  logic [15:0] i_mem_di
);
  state_t      st;
  logic        is_wr;
  logic [8:0]  cnt;
  logic [15:0] tmr;
  logic [1:0]  lat;
  logic [7:0]  rd_lo;
  logic        rx_wait;

  // States that expect another frame byte; only these run the timeout.
  assign rx_wait = st inside {ADDR_H, ADDR_L, CNT, WD_H, WD_L};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st         <= IDLE;
      is_wr      <= 1'b0;
      cnt        <= '0;
      tmr        <= '0;
      lat        <= '0;
      rd_lo      <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_cpu_hold <= 1'b0;
      o_mem_ad   <= '0;
      o_mem_do   <= '0;
      o_mem_sw   <= 1'b0;
      o_mem_lw   <= 1'b0;
    end else begin
      o_mem_sw <= 1'b0;
      if (rx_wait && !i_rx_valid) tmr <= tmr + 16'd1;
      else                        tmr <= '0;

      case (st)
        IDLE: if (i_rx_valid) begin
          if (i_rx_data == OP_WR || i_rx_data == OP_RD) begin
            is_wr      <= (i_rx_data == OP_WR);
            o_cpu_hold <= 1'b1;
            st         <= ADDR_H;
          end else begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= RSP_NAK;
            st         <= RESP;
          end
        end
        ADDR_H: if (i_rx_valid) begin
          o_mem_ad[15:8] <= i_rx_data;
          st             <= ADDR_L;
        end
        ADDR_L: if (i_rx_valid) begin
          o_mem_ad[7:0] <= {i_rx_data[7:1], 1'b0};
          st            <= CNT;
        end
        CNT: if (i_rx_valid) begin
          cnt <= {(i_rx_data == 8'h00), i_rx_data};
          if (is_wr) st <= WD_H;
          else begin
            o_mem_lw <= 1'b1;
            lat      <= '0;
            st       <= RREQ;
          end
        end
        WD_H: if (i_rx_valid) begin
          o_mem_do[15:8] <= i_rx_data;
          st             <= WD_L;
        end
        WD_L: if (i_rx_valid) begin
          o_mem_do[7:0] <= i_rx_data;
          o_mem_sw      <= 1'b1;
          st            <= WSTORE;
        end
        WSTORE: begin
          o_mem_ad <= o_mem_ad + 16'd2;
          cnt      <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= RSP_ACK;
            st         <= RESP;
          end else st <= WD_H;
        end
        RREQ, RWAIT: begin
          if (lat == 2'(RD_LAT - 1)) begin
            o_mem_lw   <= 1'b0;
            rd_lo      <= i_mem_di[7:0];
            o_tx_valid <= 1'b1;
            o_tx_data  <= i_mem_di[15:8];
            st         <= TX_H;
          end else begin
            lat <= lat + 2'd1;
            st  <= RWAIT;
          end
        end
        TX_H: if (i_tx_ready) begin
          o_tx_data <= rd_lo;
          st        <= TX_L;
        end
        TX_L: if (i_tx_ready) begin
          o_tx_valid <= 1'b0;
          o_mem_ad   <= o_mem_ad + 16'd2;
          cnt        <= cnt - 9'd1;
          if (cnt == 9'd1) begin
            o_cpu_hold <= 1'b0;
            st         <= IDLE;
          end else begin
            o_mem_lw <= 1'b1;
            lat      <= '0;
            st       <= RREQ;
          end
        end
        RESP: if (i_tx_ready) begin
          o_tx_valid <= 1'b0;
          o_cpu_hold <= 1'b0;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase

      // Host went silent mid-frame: abandon it and report NAK.
      if (rx_wait && !i_rx_valid && tmr == 16'(TIMEOUT - 1)) begin
        tmr        <= '0;
        o_tx_valid <= 1'b1;
        o_tx_data  <= RSP_NAK;
        st         <= RESP;
      end
    end
  end
endmodule

// File: tb/tb_mem_dbg_loader.sv
// Directed bench for mem_dbg_loader with a frame-level expectation model.
module tb_mem_dbg_loader;
  localparam int RD_LAT = 2;
  localparam int TO     = 100;

  logic        i_clk = 1'b0;
  logic        i_rst, i_rx_valid, i_tx_ready;
  logic [7:0]  i_rx_data;
  logic        o_tx_valid, o_cpu_hold, o_mem_sw, o_mem_lw;
  logic [7:0]  o_tx_data;
  logic [15:0] o_mem_ad, o_mem_do, i_mem_di;

  logic [15:0] ram  [0:32767];
  logic [15:0] mmem [0:32767];
  logic [15:0] exp_sw_ad[$], exp_sw_d[$];
  logic [7:0]  exp_tx[$];
  logic        hold_low = 1'b0;
  int total = 0, bad = 0;

  always #5 i_clk = ~i_clk;
  assign i_mem_di = o_mem_lw ? ram[o_mem_ad[15:1]] : 16'h0000;

  mem_dbg_loader #(.RD_LAT(RD_LAT), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_cpu_hold(o_cpu_hold), .o_mem_ad(o_mem_ad), .o_mem_do(o_mem_do),
    .o_mem_sw(o_mem_sw), .o_mem_lw(o_mem_lw), .i_mem_di(i_mem_di)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Per-cycle checker of bus strobes and transmitted bytes against the model queues.
  task automatic monitor();
    int lw_run = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        lw_run = 0; pv = 1'b0;
        continue;
      end
      if (o_mem_sw && o_mem_lw) fail("sw_lw_overlap", o_mem_ad);
      if (o_mem_sw) begin
        if (exp_sw_ad.size() == 0) fail("sw_unexpected", {o_mem_ad, o_mem_do});
        else begin
          chk("sw_addr", o_mem_ad, exp_sw_ad.pop_front());
          chk("sw_data", o_mem_do, exp_sw_d.pop_front());
        end
        ram[o_mem_ad[15:1]] = o_mem_do;
      end
      if (o_mem_lw) lw_run++;
      else if (lw_run != 0) begin
        chk("lw_len", lw_run, RD_LAT);
        lw_run = 0;
      end
      if (pv && !pr) chk("tx_stable", {o_tx_valid, o_tx_data}, {1'b1, pd});
      if (o_tx_valid && i_tx_ready) begin
        if (exp_tx.size() == 0) fail("tx_unexpected", o_tx_data);
        else chk("tx_byte", o_tx_data, exp_tx.pop_front());
      end
      if (hold_low && o_cpu_hold) fail("hold_in_idle", o_cpu_hold);
      pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b1; i_rx_data = b;
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    repeat (3) @(posedge i_clk);
  endtask

  task automatic wr2(input logic [15:0] a, input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] aa = {a[15:1], 1'b0};
    exp_sw_ad.push_back(aa);            exp_sw_d.push_back(w0); mmem[aa[15:1]] = w0;
    aa = aa + 16'd2;
    exp_sw_ad.push_back(aa);            exp_sw_d.push_back(w1); mmem[aa[15:1]] = w1;
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'd2);
    send_byte(w0[15:8]); send_byte(w0[7:0]); send_byte(w1[15:8]); send_byte(w1[7:0]);
  endtask

  task automatic rd(input logic [15:0] a, input int n);
    logic [15:0] aa = {a[15:1], 1'b0};
    for (int k = 0; k < n; k++) begin
      exp_tx.push_back(mmem[aa[15:1]][15:8]);
      exp_tx.push_back(mmem[aa[15:1]][7:0]);
      aa = aa + 16'd2;
    end
    send_byte(8'h52); send_byte(a[15:8]); send_byte(a[7:0]); send_byte(8'(n));
  endtask

  task automatic expect_done(input string name);
    int t = 0;
    while (t < 3000 && (exp_tx.size() != 0 || exp_sw_ad.size() != 0 || o_tx_valid ||
                        o_cpu_hold || o_mem_lw)) begin
      @(negedge i_clk); t++;
    end
    chk({name, "_done"}, {exp_tx.size() == 0, exp_sw_ad.size() == 0, o_cpu_hold}, 3'b110);
  endtask

  task automatic stimulus();
    int lat;
    i_rst = 1'b1; i_rx_valid = 1'b0; i_rx_data = '0; i_tx_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_flags", {o_tx_valid, o_cpu_hold, o_mem_sw, o_mem_lw}, 4'b0000);
    chk("rst_bus", {o_mem_ad, o_mem_do}, 32'h0);
    chk("rst_txd", o_tx_data, 8'h00);
    @(posedge i_clk); #1 i_rst = 1'b0;

    wr2(16'h0006, 16'hCAFE, 16'h1357);
    expect_done("wr1");
    chk("ram3", ram[3], 16'hCAFE);
    chk("ram4", ram[4], 16'h1357);

    rd(16'h0006, 2);
    expect_done("rd1");
    chk("hold_after_rd", o_cpu_hold, 1'b0);

    hold_low = 1'b1;
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    expect_done("nak");
    hold_low = 1'b0;

    wr2(16'hFFFE, 16'h1122, 16'h3344);
    expect_done("wrap");
    chk("ram_top", ram[32767], 16'h1122);
    chk("ram0", ram[0], 16'h3344);

    exp_tx.push_back(8'h15);
    send_byte(8'h57); send_byte(8'h00);
    @(posedge i_clk); #1 i_rx_valid = 1'b1; i_rx_data = 8'h10;
    @(posedge i_clk); #1 i_rx_valid = 1'b0;
    lat = 0;
    while (!o_tx_valid && lat < 1000) begin @(negedge i_clk); lat++; end
    chk("timeout_lat", (lat >= TO && lat <= TO + 2), 1'b1);
    expect_done("timeout");
    wr2(16'h0040, 16'hA1B2, 16'hC3D4);
    expect_done("after_to");
    chk("ram32", ram[32], 16'hA1B2);

    i_tx_ready = 1'b0;
    rd(16'h0006, 1);
    lat = 0;
    while (!o_tx_valid && lat < 100) begin @(negedge i_clk); lat++; end
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk("bp_hold", {o_tx_valid, o_tx_data}, {1'b1, 8'hCA});
    end
    @(posedge i_clk); #1 i_tx_ready = 1'b1;
    expect_done("bp");

    exp_sw_ad.push_back(16'h0020); exp_sw_d.push_back(16'hAABB); mmem[16] = 16'hAABB;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("pre_rst_hold", o_cpu_hold, 1'b1);
    @(posedge i_clk); #1 i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("mid_rst_flags", {o_tx_valid, o_cpu_hold, o_mem_sw, o_mem_lw}, 4'b0000);
    chk("mid_rst_bus", {o_mem_ad, o_mem_do}, 32'h0);
    chk("mid_rst_sw_seen", exp_sw_ad.size(), 0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    wr2(16'h0020, 16'h5566, 16'h7788);
    expect_done("wr_after_rst");
    rd(16'h0020, 2);
    expect_done("rd_after_rst");
    chk("ram17", ram[17], 16'h7788);
  endtask

  initial begin
    for (int k = 0; k < 32768; k++) begin ram[k] = 16'h0000; mmem[k] = 16'h0000; end
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
